// File: rtl/dm_bus_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, RAM array cleared on reset.
// Optional write trace enabled by defining DM_TRACE_EN.
module dm_bus_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       mem_q [DEPTH];

    logic              acc_go;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [3:0]        acc_be;
    logic [31:0]       acc_wdata;
    logic [ADDR_W-1:0] acc_idx;
    logic              acc_err;
    logic [31:0]       acc_merged;

    // With zero wait states the access happens on the accepting edge, so it must use the live inputs.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_be    = be_q;
        acc_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_be    = req_be;
            acc_wdata = req_wdata;
        end
        acc_idx = acc_addr[ADDR_W+1:2];
        acc_err = (acc_addr >> (ADDR_W + 2)) != 32'd0;
        for (int i = 0; i < 4; i++) begin
            acc_merged[8*i +: 8] = acc_be[i] ? acc_wdata[8*i +: 8] : mem_q[acc_idx][8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        acc_go  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        acc_go  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    acc_go  = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (acc_go) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_we) ? 32'd0 : mem_q[acc_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        be_q    <= be_d;
        wdata_q <= wdata_d;
    end

    // A reset that lands before the RESP-entry edge drops the pending write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (acc_go && acc_we && !acc_err) begin
            mem_q[acc_idx] <= acc_merged;
        end
    end

`ifdef DM_TRACE_EN
    logic [31:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (state_q == S_IDLE && req_valid) begin
            pc_d = req_pc;
        end
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    always_ff @(posedge clk) begin
        if (reset && acc_go && acc_we && !acc_err && acc_be != 4'd0) begin
            $display("@%h: *%h <= %h", (state_q == S_IDLE) ? req_pc : pc_q, {acc_idx, 2'b00}, acc_merged);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dm_bus_responder.sv
// Directed bench for dm_bus_responder (ADDR_W=10, WAIT_CYCLES=2).
module tb_dm_bus_responder;
    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    dm_bus_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Issues one request from IDLE with rsp_ready high; lat counts rising edges from the
    // accepting edge (inclusive) to the edge after which rsp_valid is seen. Returns at a negedge in IDLE.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                       output int lat);
        bit got = 0;
        rdata = 32'hx;
        err   = 1'bx;
        lat   = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        req_pc    = 32'h0000_1000 + addr;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            lat++;
            #1 req_valid = 1'b0;
            @(negedge clk);
            if (rsp_valid) begin
                got   = 1;
                rdata = rsp_rdata;
                err   = rsp_err;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout addr=%h: rsp_valid never rose", addr);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic        er;
        int          lat;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++;
        if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_data got=%h/%b exp=0/0", rsp_rdata, rsp_err);
        end
        reset = 1'b1;
        @(negedge clk);
        txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL reset_read10 got=%h/%b exp=0/0", rd, er); end
    endtask

    task automatic test_write_read;
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(1'b1, 32'h0000_0004, 4'hF, 32'hDEAD_BEEF, rd, er, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL wr_latency got=%0d exp=3", lat); end
        checks++;
        if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL wr_rsp got=%h/%b exp=0/0", rd, er); end
        txn(1'b0, 32'h0000_0004, 4'h0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            errors++; $display("FAIL rd_after_wr got=%h/%b exp=deadbeef/0", rd, er);
        end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_byte_merge;
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(1'b1, 32'h0000_0008, 4'hF, 32'h1122_3344, rd, er, lat);
        txn(1'b1, 32'h0000_000B, 4'b0101, 32'hAABB_CCDD, rd, er, lat);
        txn(1'b0, 32'h0000_0008, 4'h0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL byte_merge got=%h exp=11bb33dd", rd); end
        txn(1'b1, 32'h0000_0008, 4'b0000, 32'hFFFF_FFFF, rd, er, lat);
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL be0_err got=%b exp=0", er); end
        txn(1'b0, 32'h0000_0008, 4'h0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL be0_noop got=%h exp=11bb33dd", rd); end
    endtask

    task automatic test_error;
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(1'b0, 32'h0000_1000, 4'hF, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_read got=%h/%b exp=0/1", rd, er); end
        txn(1'b1, 32'h0000_1004, 4'hF, 32'h0BAD_0BAD, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_write got=%h/%b exp=0/1", rd, er); end
        txn(1'b0, 32'h0000_0004, 4'h0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            errors++; $display("FAIL err_no_alias got=%h/%b exp=deadbeef/0", rd, er);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          got = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0004; req_be = 4'h0; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
            else @(posedge clk);
        end
        checks++;
        if (!got) begin errors++; $display("FAIL bp_timeout rsp_valid=%b exp=1", rsp_valid); end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0004; req_be = 4'hF; req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b exp v=1 d=deadbeef rdy=0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL bp_release got v=%b rdy=%b d=%h exp v=0 rdy=1 d=0", rsp_valid, req_ready, rsp_rdata);
        end
        txn(1'b0, 32'h0000_0004, 4'h0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_ignored_req got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0004; req_be = 4'h0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid) n++;
        end
        req_valid = 1'b0;
        checks++;
        if (n !== 3) begin errors++; $display("FAIL b2b_throughput got=%0d exp=3 responses in 12 cycles", n); end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got=%b exp=1", req_ready); end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] rd;
        logic        er;
        int          lat;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_000C; req_be = 4'hF; req_wdata = 32'h5555_5555;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL midwait_reset got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, req_ready);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midwait_late%0d got=%b exp=0", i, rsp_valid); end
        end
        txn(1'b0, 32'h0000_000C, 4'h0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL midwait_read got=%h exp=0", rd); end
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_be    = 4'd0;
        req_wdata = 32'd0;
        req_pc    = 32'd0;
        rsp_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_merge();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
